// File: rtl/serial_msg_pkg.sv
// Shared constants for the 1-bit serial message link (transmitter and receiver).
// Line levels, default message width and the receiver/transmitter state encoding.
package serial_msg_pkg;

   localparam int   MSG_W_DEF = 10;
   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;
   localparam logic IDLE_LVL  = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/serial_msg_rx_tick.sv
// bit_tick_gen: per-bit sampling strobe for serial_msg_rx.
// Fast mode ticks every clock; slow mode ticks once every BIT_DIV clocks, with load presetting half a bit.
module bit_tick_gen #(
   parameter int BIT_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic mode_q,
   input  logic load,
   output logic tick
);

   localparam int CW = $clog2(BIT_DIV);
   localparam logic [CW-1:0] HALF = CW'(BIT_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BIT_DIV - 1);

   logic [CW-1:0] cnt;

   // Held at the half-bit preset while idle, so the first tick after a start lands mid start bit.
   // The natural wrap to FULL then places every later tick in the middle of its bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= HALF;
      else if (cnt == '0)
         cnt <= FULL;
      else
         cnt <= cnt - 1'b1;
   end

   assign tick = mode_q ? (cnt == '0) : 1'b1;

endmodule

// File: rtl/serial_msg_rx.sv
// serial_msg_rx: deserialises start/data/[parity]/stop frames from the serial link into a message.
// Optional parity bit (even parity over the data bits) enabled by defining SERIAL_MSG_RX_PARITY_EN.
module serial_msg_rx
   import serial_msg_pkg::*;
#(
   parameter int MSG_W   = MSG_W_DEF,
   parameter int BIT_DIV = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             mode,
   output logic [MSG_W-1:0] data_out,
   output logic             valid,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err
);

   localparam int CW = $clog2(MSG_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(MSG_W - 1);

   state_t           state;
   logic             mode_q;
   logic             tick;
   logic [CW-1:0]    bit_cnt;
   logic [MSG_W-1:0] shift;
`ifdef SERIAL_MSG_RX_PARITY_EN
   logic             par_acc;
   logic             par_bad;
`else
   assign parity_err = 1'b0;
`endif

   bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .mode_q (mode_q),
      .load   (state == IDLE),
      .tick   (tick)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         bit_cnt   <= '0;
         shift     <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef SERIAL_MSG_RX_PARITY_EN
         par_acc    <= 1'b0;
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef SERIAL_MSG_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (sin == START_BIT) begin
                  mode_q  <= mode;
                  bit_cnt <= '0;
                  shift   <= '0;
`ifdef SERIAL_MSG_RX_PARITY_EN
                  par_acc <= 1'b0;
                  par_bad <= 1'b0;
`endif
                  state   <= mode ? START : DATA;
               end
            end
            // Slow mode only: a start bit that is gone by mid-bit is treated as line noise.
            START: begin
               if (tick)
                  state <= (sin == START_BIT) ? DATA : IDLE;
            end
            DATA: begin
               if (tick) begin
                  shift <= {shift[MSG_W-2:0], sin};
`ifdef SERIAL_MSG_RX_PARITY_EN
                  par_acc <= par_acc ^ sin;
`endif
                  if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_MSG_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef SERIAL_MSG_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  par_bad <= par_acc ^ sin;
                  state   <= STOP;
               end
            end
`endif
            // A bad stop bit outranks a parity mismatch; only one pulse per frame.
            STOP: begin
               if (tick) begin
                  state <= IDLE;
                  if (sin != STOP_BIT) begin
                     frame_err <= 1'b1;
                  end
`ifdef SERIAL_MSG_RX_PARITY_EN
                  else if (par_bad) begin
                     parity_err <= 1'b1;
                  end
`endif
                  else begin
                     data_out <= shift;
                     valid    <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_msg_rx.sv
// Testbench for serial_msg_rx: directed frames, expected pulses queued at issue time and
// checked by an independent monitor (kind, cycle, data_out, busy, exclusivity).
module tb_serial_msg_rx;

   localparam int MSG_W   = 10;
   localparam int BIT_DIV = 8;
`ifdef SERIAL_MSG_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int K_VALID = 0;
   localparam int K_FERR  = 1;
   localparam int K_PERR  = 2;

   typedef struct {
      int               kind;
      logic [MSG_W-1:0] data;
      int               cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             sin;
   logic             mode;
   logic [MSG_W-1:0] data_out;
   logic             valid;
   logic             busy;
   logic             frame_err;
   logic             parity_err;

   int               checks   = 0;
   int               errors   = 0;
   int               cyc      = 0;
   int               busyRun  = 0;
   int               lastBusy = 0;
   logic [MSG_W-1:0] lastGood = '0;
   exp_t             expq[$];

   serial_msg_rx #(.MSG_W(MSG_W), .BIT_DIV(BIT_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .mode       (mode),
      .data_out   (data_out),
      .valid      (valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic driveBit(input logic b, input int div);
      sin = b;
      repeat (div) @(negedge clk);
   endtask

   // Entered and left just after a falling edge; the start bit is sampled at the next rising edge.
   task automatic applyStimulus(input logic m, input logic [MSG_W-1:0] d, input logic flipPar,
                                input logic stopb, input int gap);
      int   div;
      int   lat;
      logic parb;
      exp_t e;
      div  = m ? BIT_DIV : 1;
      lat  = m ? (BIT_DIV / 2 + (MSG_W + 1 + PAR) * BIT_DIV) : (MSG_W + 1 + PAR);
      parb = (^d) ^ flipPar;
      e.cyc = cyc + 1 + lat;
      if (stopb != 1'b0) begin
         e.kind = K_FERR;
         e.data = lastGood;
      end else if (PAR != 0 && flipPar) begin
         e.kind = K_PERR;
         e.data = lastGood;
      end else begin
         e.kind   = K_VALID;
         e.data   = d;
         lastGood = d;
      end
      expq.push_back(e);
      mode = m;
      driveBit(1'b1, div);
      for (int i = MSG_W - 1; i >= 0; i--) driveBit(d[i], div);
      if (PAR != 0) driveBit(parb, div);
      driveBit(stopb, div);
      if (gap > 0) begin
         sin = 1'b0;
         repeat (gap) @(negedge clk);
         checkOutput("busy_len", lastBusy, lat);
      end
   endtask

   // Monitor: busy run lengths and every output pulse against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      if (busy) begin
         busyRun++;
      end else if (busyRun != 0) begin
         lastBusy = busyRun;
         busyRun  = 0;
      end
      if (valid || frame_err || parity_err) begin
         checkOutput("one_pulse", int'(valid) + int'(frame_err) + int'(parity_err), 1);
         checkOutput("busy_at_pulse", int'(busy), 0);
         if (expq.size() == 0) begin
            checkOutput("unexpected_pulse", 1, 0);
         end else begin
            e    = expq.pop_front();
            kind = valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
            checkOutput("pulse_kind", kind, e.kind);
            checkOutput("pulse_cycle", cyc, e.cyc);
            checkOutput("data_out", int'(data_out), int'(e.data));
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst  = 1'b1;
      sin  = 1'b0;
      mode = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", int'(valid), 0);
      checkOutput("rst_frame_err", int'(frame_err), 0);
      checkOutput("rst_parity_err", int'(parity_err), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_data_out", int'(data_out), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] T1 fast frame");
      applyStimulus(1'b0, 10'b1000110101, 1'b0, 1'b0, 3);
      $display("[TB] back-to-back fast frames");
      applyStimulus(1'b0, 10'h3FF, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 3);
      $display("[TB] T2 slow frame");
      applyStimulus(1'b1, 10'b1001101101, 1'b0, 1'b0, 3);
      $display("[TB] T3 fast frame with bad stop bit");
      applyStimulus(1'b0, 10'h155, 1'b0, 1'b1, 3);
      applyStimulus(1'b0, 10'h001, 1'b0, 1'b0, 3);

      $display("[TB] T4 slow start glitch");
      mode = 1'b1;
      sin  = 1'b1;
      repeat (2) @(negedge clk);
      sin = 1'b0;
      repeat (BIT_DIV) @(negedge clk);
      checkOutput("glitch_busy_ok", int'(lastBusy > 0 && lastBusy <= BIT_DIV / 2), 1);
      applyStimulus(1'b1, 10'h200, 1'b0, 1'b0, 3);

      $display("[TB] T5 reset mid-frame");
      mode = 1'b0;
      driveBit(1'b1, 1);
      driveBit(1'b1, 1);
      driveBit(1'b0, 1);
      driveBit(1'b1, 1);
      rst = 1'b1;
      sin = 1'b1;
      @(negedge clk);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_data_out", int'(data_out), 0);
      sin = 1'b0;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      lastGood = '0;
      @(negedge clk);
      applyStimulus(1'b0, 10'h2AA, 1'b0, 1'b0, 3);

`ifdef SERIAL_MSG_RX_PARITY_EN
      $display("[TB] T6 parity");
      applyStimulus(1'b0, 10'h235, 1'b0, 1'b0, 3);
      applyStimulus(1'b0, 10'h235, 1'b1, 1'b0, 3);
      applyStimulus(1'b0, 10'h0F0, 1'b1, 1'b1, 3);
      applyStimulus(1'b1, 10'h1C3, 1'b1, 1'b0, 3);
`endif

      for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
      checkOutput("queue_drained", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
